// File: rtl/pipelined_avg_tree.sv
// ---------------------------------------------------------------------------
// pipelined_avg_tree
//   Streaming signed averager. NCH signed channels are summed through a
//   registered binary adder tree (one level per stage). The sum is then
//   arithmetically shifted right by a per-vector amount, with optional
//   round-half-up, and saturated to DATAW bits.
//   The whole pipeline advances together under valid/ready flow control.
//   Latency is LOGN+2 clock edges, counting the edge that accepts the vector.
//
// Ports
//   Clk        clock, rising edge
//   Rst        asynchronous active-low reset (clears valids and avg/ovf)
//   in_valid   input vector valid
//   in_ready   block can accept a vector this cycle (combinational)
//   in_data    NCH x DATAW signed channels, channel k at [k*DATAW +: DATAW]
//   sa         unsigned right-shift amount, travels with its vector
//   rnd        1 = round half up, 0 = floor, travels with its vector
//   out_valid  avg/ovf hold a result
//   out_ready  consumer accepts the result
//   avg        signed averaged result
//   ovf        result was saturated
// ---------------------------------------------------------------------------
module pipelined_avg_tree #(
  parameter int DATAW = 16,
  parameter int NCH   = 8,
  parameter int SAW   = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*DATAW-1:0]    in_data,
  input  logic [SAW-1:0]          sa,
  input  logic                    rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DATAW-1:0] avg,
  output logic                    ovf
);

  localparam int LOGN = $clog2(NCH);
  // One bit above the exact-sum width so the rounding term can never overflow.
  localparam int ACCW = DATAW + LOGN + 1;

  if (NCH < 2 || NCH > 32 || (1 << LOGN) != NCH) begin : g_bad_nch
    $fatal(1, "pipelined_avg_tree: NCH must be a power of two in 2..32");
  end

  // Arithmetic right shift with optional round-half-up. Shifts of ACCW or
  // more collapse to sign fill and ignore the rounding request.
  function automatic logic signed [ACCW-1:0] shift_round(
    input logic signed [ACCW-1:0] s,
    input logic [SAW-1:0]         amt,
    input logic                   r
  );
    logic signed [ACCW-1:0] t;
    t = s;
    if (int'(amt) >= ACCW) return {ACCW{s[ACCW-1]}};
    if (r && amt != '0) t = s + $signed(ACCW'(1) << (amt - SAW'(1)));
    return t >>> amt;
  endfunction

  // Returns {ovf, value} clamped to the signed DATAW range.
  function automatic logic [DATAW:0] saturate(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] vmax;
    logic signed [ACCW-1:0] vmin;
    vmax = $signed({{(LOGN+2){1'b0}}, {(DATAW-1){1'b1}}});
    vmin = $signed({{(LOGN+2){1'b1}}, {(DATAW-1){1'b0}}});
    if (v > vmax) return {1'b1, 1'b0, {(DATAW-1){1'b1}}};
    if (v < vmin) return {1'b1, 1'b1, {(DATAW-1){1'b0}}};
    return {1'b0, v[DATAW-1:0]};
  endfunction

  // The pipeline moves only when the output slot is empty or being drained.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---- S0: capture and sign-extend the input vector ----
  logic signed [ACCW-1:0] sum_p0 [NCH];
  logic [SAW-1:0]         sa_p0;
  logic                   rnd_p0;
  logic                   vld_p0;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= in_valid;
  end

  always_ff @(posedge Clk) begin
    if (advance) begin
      for (int k = 0; k < NCH; k++)
        sum_p0[k] <= ACCW'($signed(in_data[k*DATAW +: DATAW]));
      sa_p0  <= sa;
      rnd_p0 <= rnd;
    end
  end

  // ---- S1..SLOGN: one adder-tree level per stage ----
  for (genvar l = 1; l <= LOGN; l++) begin : g_lvl
    localparam int N = NCH >> l;

    logic signed [ACCW-1:0] prv [2*N];
    logic [SAW-1:0]         prv_sa;
    logic                   prv_rnd;
    logic                   prv_vld;

    logic signed [ACCW-1:0] sum_pn [N];
    logic [SAW-1:0]         sa_pn;
    logic                   rnd_pn;
    logic                   vld_pn;

    if (l == 1) begin : g_from_p0
      assign prv     = sum_p0;
      assign prv_sa  = sa_p0;
      assign prv_rnd = rnd_p0;
      assign prv_vld = vld_p0;
    end else begin : g_from_prev
      assign prv     = g_lvl[l-1].sum_pn;
      assign prv_sa  = g_lvl[l-1].sa_pn;
      assign prv_rnd = g_lvl[l-1].rnd_pn;
      assign prv_vld = g_lvl[l-1].vld_pn;
    end

    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) vld_pn <= 1'b0;
      else if (advance) vld_pn <= prv_vld;
    end

    always_ff @(posedge Clk) begin
      if (advance) begin
        for (int i = 0; i < N; i++)
          sum_pn[i] <= prv[2*i] + prv[2*i+1];
        sa_pn  <= prv_sa;
        rnd_pn <= prv_rnd;
      end
    end
  end

  // ---- SF: shift, round, saturate and register the result ----
  logic signed [ACCW-1:0] shr_pf;
  logic [DATAW:0]         sat_pf;

  assign shr_pf = shift_round(g_lvl[LOGN].sum_pn[0], g_lvl[LOGN].sa_pn,
                              g_lvl[LOGN].rnd_pn);
  assign sat_pf = saturate(shr_pf);

  // Bubbles clear out_valid but leave the last result on avg/ovf.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid <= 1'b0;
      avg       <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= g_lvl[LOGN].vld_pn;
      if (g_lvl[LOGN].vld_pn) begin
        ovf <= sat_pf[DATAW];
        avg <= $signed(sat_pf[DATAW-1:0]);
      end
    end
  end

endmodule

// File: doc/pipelined_avg_tree.md
Name: pipelined_avg_tree

Overview:
Parametrised, fully pipelined signed averager. It sums NCH signed DATAW-bit channels through a registered adder tree, then arithmetic-shifts the sum right by a per-sample amount, with optional round-to-nearest and output saturation. It is the streaming successor to the fixed 8-input averaging datapath. It adds valid/ready flow control, so it can sit between producer and consumer blocks that stall.

Parameters:
DATAW, 16, width of each signed input channel and of the output
NCH, 8, number of input channels; power of two, 2..32
SAW, 8, width of the shift-amount input
(derived) LOGN = log2(NCH); ACCW = DATAW+LOGN+1, internal accumulator width (includes a rounding headroom bit)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous active-low reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept an input vector this cycle
in_data  input  NCH*DATAW  channel k at bits [k*DATAW +: DATAW], signed
sa  input  SAW  unsigned right-shift amount, sampled with in_data
rnd  input  1  1 = round half up (toward +inf), 0 = floor; sampled with in_data
out_valid  output  1  avg/ovf hold a result
out_ready  input  1  consumer accepts the result
avg  output  DATAW  signed averaged result
ovf  output  1  result was saturated

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-low, on Rst. While Rst=0: all stage valid bits, out_valid, avg and ovf are 0. Reset during operation discards every in-flight vector. There is no partial output.
- Pipeline stages:
  - S0: capture the input vector, sign-extended to ACCW, plus sa and rnd.
  - S1..SLOGN: one adder-tree level per stage. Level i adds adjacent pairs.
  - SF: shift, round and saturate, then register into avg/ovf.
- Latency: LOGN+2 cycles from the accepting edge to out_valid=1 when there is no stall. For NCH=8 this is 5 cycles.
- sa and rnd travel with their vector. Vectors issued back-to-back may use different modes.
- Flow control:
  - advance = ~out_valid | out_ready.
  - in_ready = advance, so it is combinational from out_ready and out_valid.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - When advance=0 the whole pipeline freezes. avg, ovf and out_valid stay stable, and nothing is lost or duplicated.
  - Bubble-squeezing is not required. Throughput is 1 vector per cycle when out_ready=1.
- Arithmetic:
  - The sum is exact in ACCW bits; no overflow is possible.
  - Shift: if rnd=1 and 0<sa<ACCW, add 2^(sa-1) before the arithmetic right shift. Otherwise no rounding term is added.
  - If sa >= ACCW, the result is sign-fill (0 or -1) and rnd is ignored.
  - sa=0 passes the sum through.
- Saturation: if the shifted value is greater than 2^(DATAW-1)-1, avg = max positive and ovf=1. If it is less than -2^(DATAW-1), avg = max negative and ovf=1. Otherwise avg = the low DATAW bits and ovf=0.
- in_data is don't-care when in_valid=0. Bubbles propagate with valid=0 and do not change avg.
- NCH=2 gives a one-level tree (latency 3). Elaborating with a non-power-of-two NCH must cause a fatal error.

Test Plan:
- Uniform input: NCH=8, all channels 100, sa=3, rnd=0, one vector → after 5 cycles out_valid=1, avg=100, ovf=0.
- Rounding: channels 1..8 (sum 36), sa=3 → avg=4 with rnd=0 and avg=5 with rnd=1. Channels -1..-8 (sum -36) → avg=-5 with rnd=0 and avg=-4 with rnd=1.
- Saturation and shift edges:
  - All 32767, sa=0 → avg=32767, ovf=1.
  - All -32768, sa=0 → avg=-32768, ovf=1.
  - All -1, sa=200 → avg=-1, ovf=0.
- Back-to-back stream: 20 consecutive vectors with random data, sa and rnd, out_ready=1 → 20 results in order, 1 per cycle, each matching the reference model.
- Backpressure:
  - Stream 6 vectors while out_ready is driven low for 3 cycles after the first result.
  - Required: in_ready=0 during the stall, and avg/out_valid held constant.
  - All 6 results are delivered exactly once, in order.
- Reset mid-stream: assert Rst=0 asynchronously (off the clock edge) with 3 vectors in flight → out_valid, avg and ovf go to 0 immediately. After release, no stale results appear, and the next vector emerges after 5 cycles.
